// File: rtl/config_pkg.sv
// Shared configuration and storage types for the speculative GHR checkpoint queue.
package config_pkg;

    typedef struct packed {
        int unsigned ghr_bits;
        int unsigned depth;
    } cfg_t;

    localparam cfg_t        CFG     = '{ghr_bits: 32'd8, depth: 32'd8};
    localparam int unsigned GHR_W   = CFG.ghr_bits;
    localparam int unsigned DEPTH_N = CFG.depth;
    localparam int unsigned IDX_W   = $clog2(DEPTH_N);

    // Extra MSB is the wrap bit that distinguishes full from empty.
    typedef logic [IDX_W:0] ptr_t;

    typedef struct packed {
        logic             valid;
        logic             resolved;
        logic [31:0]      pc;
        logic [GHR_W-1:0] ghr_before;
        logic             pred_taken;
        logic             actual_taken;
    } entry_t;

    function automatic logic [GHR_W-1:0] ghr_push(input logic [GHR_W-1:0] ghr,
                                                  input logic             bit_in);
        return {ghr[GHR_W-2:0], bit_in};
    endfunction

endpackage

// File: rtl/ghr_ckpt_q.sv
// In-flight branch queue: checkpoints the speculative GHR per predicted branch,
// repairs it on mispredict or flush, and trains the predictor in program order.
module ghr_ckpt_q
    import config_pkg::*;
#(
    parameter int GHR_BITS = GHR_W,
    parameter int DEPTH    = DEPTH_N,
    parameter int TAG_W    = $clog2(DEPTH)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                alloc_valid_i,
    output logic                alloc_ready_o,
    input  logic [31:0]         alloc_pc_i,
    input  logic                alloc_pred_taken_i,
    output logic [TAG_W-1:0]    alloc_tag_o,
    output logic [GHR_BITS-1:0] spec_ghr_o,
    input  logic                resolve_valid_i,
    input  logic [TAG_W-1:0]    resolve_tag_i,
    input  logic                resolve_taken_i,
    input  logic                flush_i,
    output logic                update_valid_o,
    output logic [31:0]         update_pc_o,
    output logic [GHR_BITS-1:0] update_ghr_o,
    output logic                update_taken_o
);

    entry_t              ent_q [DEPTH];
    entry_t              ent_d [DEPTH];
    ptr_t                head_q, head_d, tail_q, tail_d;
    logic [GHR_BITS-1:0] spec_ghr_q, spec_ghr_d, cmt_ghr_q, cmt_ghr_d;
    logic                upd_valid_q, upd_valid_d;
    logic [31:0]         upd_pc_q, upd_pc_d;
    logic [GHR_BITS-1:0] upd_ghr_q, upd_ghr_d;
    logic                upd_taken_q, upd_taken_d;

    logic [TAG_W-1:0]    head_idx_s, tail_idx_s, res_off_s;
    ptr_t                count_s;
    logic                full_s, commit_s, res_hit_s, mispredict_s, alloc_fire_s;

    assign head_idx_s = head_q[TAG_W-1:0];
    assign tail_idx_s = tail_q[TAG_W-1:0];
    assign count_s    = tail_q - head_q;
    // Registered occupancy only: a commit in this cycle does not open a slot yet.
    assign full_s     = (count_s == ptr_t'(DEPTH));
    assign commit_s   = ent_q[head_idx_s].valid && ent_q[head_idx_s].resolved;
    assign res_hit_s  = resolve_valid_i && ent_q[resolve_tag_i].valid && !flush_i;
    assign mispredict_s = res_hit_s && (resolve_taken_i != ent_q[resolve_tag_i].pred_taken);
    assign alloc_fire_s = alloc_valid_i && !full_s && !mispredict_s && !flush_i;
    assign res_off_s  = resolve_tag_i - head_idx_s;

    assign alloc_ready_o  = !full_s;
    assign alloc_tag_o    = tail_idx_s;
    assign spec_ghr_o     = spec_ghr_q;
    assign update_valid_o = upd_valid_q;
    assign update_pc_o    = upd_pc_q;
    assign update_ghr_o   = upd_ghr_q;
    assign update_taken_o = upd_taken_q;

    // Next-state for queue storage, pointers, GHRs and the training outputs.
    always_comb begin
        ent_d       = ent_q;
        head_d      = head_q;
        tail_d      = tail_q;
        spec_ghr_d  = spec_ghr_q;
        cmt_ghr_d   = cmt_ghr_q;
        upd_valid_d = 1'b0;
        upd_pc_d    = upd_pc_q;
        upd_ghr_d   = upd_ghr_q;
        upd_taken_d = upd_taken_q;

        ent_d[resolve_tag_i].resolved     = ent_q[resolve_tag_i].resolved | res_hit_s;
        ent_d[resolve_tag_i].actual_taken = res_hit_s ? resolve_taken_i
                                                      : ent_q[resolve_tag_i].actual_taken;

        if (commit_s) begin
            ent_d[head_idx_s].valid = 1'b0;
            head_d      = head_q + ptr_t'(1'b1);
            cmt_ghr_d   = ghr_push(cmt_ghr_q, ent_q[head_idx_s].actual_taken);
            upd_valid_d = 1'b1;
            upd_pc_d    = ent_q[head_idx_s].pc;
            upd_ghr_d   = ent_q[head_idx_s].ghr_before;
            upd_taken_d = ent_q[head_idx_s].actual_taken;
        end else begin
            upd_valid_d = 1'b0;
        end

        if (flush_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_d[i].valid = 1'b0;
            end
            tail_d     = head_d;
            spec_ghr_d = cmt_ghr_d;
        end else if (mispredict_s) begin
            // Age is the distance from head; anything older-than-or-equal survives.
            for (int i = 0; i < DEPTH; i++) begin
                ent_d[i].valid = ent_d[i].valid && !((TAG_W'(i) - head_idx_s) > res_off_s);
            end
            tail_d     = head_q + ptr_t'(res_off_s) + ptr_t'(1'b1);
            spec_ghr_d = ghr_push(ent_q[resolve_tag_i].ghr_before, resolve_taken_i);
        end else if (alloc_fire_s) begin
            ent_d[tail_idx_s] = '{valid:        1'b1,
                                  resolved:     1'b0,
                                  pc:           alloc_pc_i,
                                  ghr_before:   spec_ghr_q,
                                  pred_taken:   alloc_pred_taken_i,
                                  actual_taken: 1'b0};
            tail_d     = tail_q + ptr_t'(1'b1);
            spec_ghr_d = ghr_push(spec_ghr_q, alloc_pred_taken_i);
        end else begin
            tail_d     = tail_q;
            spec_ghr_d = spec_ghr_q;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ent_q       <= '{default: '0};
            head_q      <= '0;
            tail_q      <= '0;
            spec_ghr_q  <= '0;
            cmt_ghr_q   <= '0;
            upd_valid_q <= 1'b0;
            upd_pc_q    <= 32'd0;
            upd_ghr_q   <= '0;
            upd_taken_q <= 1'b0;
        end else begin
            ent_q       <= ent_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            spec_ghr_q  <= spec_ghr_d;
            cmt_ghr_q   <= cmt_ghr_d;
            upd_valid_q <= upd_valid_d;
            upd_pc_q    <= upd_pc_d;
            upd_ghr_q   <= upd_ghr_d;
            upd_taken_q <= upd_taken_d;
        end
    end

endmodule

// File: tb/tb_ghr_ckpt_q.sv
// Directed bench for ghr_ckpt_q with hand-computed expectations.
module tb_ghr_ckpt_q;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        alloc_valid_i = 1'b0;
    logic        alloc_ready_o;
    logic [31:0] alloc_pc_i = 32'd0;
    logic        alloc_pred_taken_i = 1'b0;
    logic [2:0]  alloc_tag_o;
    logic [7:0]  spec_ghr_o;
    logic        resolve_valid_i = 1'b0;
    logic [2:0]  resolve_tag_i = 3'd0;
    logic        resolve_taken_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        update_valid_o;
    logic [31:0] update_pc_o;
    logic [7:0]  update_ghr_o;
    logic        update_taken_o;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [31:0] pc_log[$];
    logic [7:0]  ghr_log[$];
    logic        tk_log[$];
    int          cyc_log[$];

    ghr_ckpt_q dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .alloc_valid_i      (alloc_valid_i),
        .alloc_ready_o      (alloc_ready_o),
        .alloc_pc_i         (alloc_pc_i),
        .alloc_pred_taken_i (alloc_pred_taken_i),
        .alloc_tag_o        (alloc_tag_o),
        .spec_ghr_o         (spec_ghr_o),
        .resolve_valid_i    (resolve_valid_i),
        .resolve_tag_i      (resolve_tag_i),
        .resolve_taken_i    (resolve_taken_i),
        .flush_i            (flush_i),
        .update_valid_o     (update_valid_o),
        .update_pc_o        (update_pc_o),
        .update_ghr_o       (update_ghr_o),
        .update_taken_o     (update_taken_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and log any training pulse seen after the edge.
    task automatic step();
        @(posedge clk_i);
        #1;
        cyc++;
        if (update_valid_o) begin
            pc_log.push_back(update_pc_o);
            ghr_log.push_back(update_ghr_o);
            tk_log.push_back(update_taken_o);
            cyc_log.push_back(cyc);
        end
    endtask

    task automatic log_clear();
        pc_log.delete();
        ghr_log.delete();
        tk_log.delete();
        cyc_log.delete();
    endtask

    task automatic idle();
        alloc_valid_i = 1'b0;
        resolve_valid_i = 1'b0;
        flush_i = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst_i = 1'b0;
        #1;
        check_eq("rst_upd_valid", 32'(update_valid_o), 32'd0);
        check_eq("rst_upd_pc", update_pc_o, 32'd0);
        check_eq("rst_upd_ghr", 32'(update_ghr_o), 32'd0);
        check_eq("rst_upd_taken", 32'(update_taken_o), 32'd0);
        check_eq("rst_spec_ghr", 32'(spec_ghr_o), 32'd0);
        check_eq("rst_ready", 32'(alloc_ready_o), 32'd1);
        check_eq("rst_tag", 32'(alloc_tag_o), 32'd0);
        step();
        rst_i = 1'b1;
        step();
        log_clear();
    endtask

    task automatic do_alloc(input logic [2:0] tag_exp, input logic [31:0] pc, input logic pred);
        check_eq("alloc_tag", 32'(alloc_tag_o), 32'(tag_exp));
        check_eq("alloc_ready", 32'(alloc_ready_o), 32'd1);
        alloc_valid_i = 1'b1;
        alloc_pc_i = pc;
        alloc_pred_taken_i = pred;
        step();
        alloc_valid_i = 1'b0;
    endtask

    task automatic do_resolve(input logic [2:0] tag, input logic taken);
        resolve_valid_i = 1'b1;
        resolve_tag_i = tag;
        resolve_taken_i = taken;
        step();
        resolve_valid_i = 1'b0;
    endtask

    initial begin
        // Allocation order, out-of-order resolve, then flush.
        do_reset();
        do_alloc(3'd0, 32'h100, 1'b1);
        do_alloc(3'd1, 32'h104, 1'b0);
        do_alloc(3'd2, 32'h108, 1'b1);
        check_eq("a_spec_ghr", 32'(spec_ghr_o), 32'h05);
        resolve_valid_i = 1'b1; resolve_tag_i = 3'd2; resolve_taken_i = 1'b1; step();
        resolve_tag_i = 3'd0; resolve_taken_i = 1'b1; step();
        resolve_tag_i = 3'd1; resolve_taken_i = 1'b0; step();
        resolve_valid_i = 1'b0;
        step(); step(); step();
        check_eq("ooo_count", 32'(pc_log.size()), 32'd3);
        check_eq("ooo_pc0", pc_log[0], 32'h100);
        check_eq("ooo_pc1", pc_log[1], 32'h104);
        check_eq("ooo_pc2", pc_log[2], 32'h108);
        check_eq("ooo_ghr0", 32'(ghr_log[0]), 32'h00);
        check_eq("ooo_ghr1", 32'(ghr_log[1]), 32'h01);
        check_eq("ooo_ghr2", 32'(ghr_log[2]), 32'h02);
        check_eq("ooo_tk", 32'({tk_log[0], tk_log[1], tk_log[2]}), 32'b101);
        check_eq("ooo_consec1", 32'(cyc_log[1] - cyc_log[0]), 32'd1);
        check_eq("ooo_consec2", 32'(cyc_log[2] - cyc_log[1]), 32'd1);
        do_alloc(3'd3, 32'h10C, 1'b1);
        do_alloc(3'd4, 32'h110, 1'b1);
        do_alloc(3'd5, 32'h114, 1'b1);
        check_eq("pre_flush_ghr", 32'(spec_ghr_o), 32'h2F);
        flush_i = 1'b1;
        alloc_valid_i = 1'b1; alloc_pred_taken_i = 1'b1;
        resolve_valid_i = 1'b1; resolve_tag_i = 3'd4; resolve_taken_i = 1'b0;
        step();
        idle();
        check_eq("flush_ghr", 32'(spec_ghr_o), 32'h05);
        check_eq("flush_ready", 32'(alloc_ready_o), 32'd1);
        check_eq("flush_tag", 32'(alloc_tag_o), 32'd3);
        do_resolve(3'd4, 1'b1);
        step(); step(); step();
        check_eq("flush_no_upd", 32'(pc_log.size()), 32'd3);
        check_eq("flush_ghr_hold", 32'(spec_ghr_o), 32'h05);

        // Reset while a resolved entry is about to commit.
        do_reset();
        do_alloc(3'd0, 32'h300, 1'b1);
        do_resolve(3'd0, 1'b1);
        rst_i = 1'b0;
        #2;
        check_eq("mid_rst_valid", 32'(update_valid_o), 32'd0);
        check_eq("mid_rst_ghr", 32'(spec_ghr_o), 32'd0);
        step(); step();
        rst_i = 1'b1;
        step(); step();
        check_eq("mid_rst_no_upd", 32'(pc_log.size()), 32'd0);
        check_eq("mid_rst_tag", 32'(alloc_tag_o), 32'd0);

        // Mispredict repair, dropped alloc, ignored resolve, commit timing.
        do_reset();
        do_alloc(3'd0, 32'h200, 1'b1);
        do_alloc(3'd1, 32'h204, 1'b1);
        do_alloc(3'd2, 32'h208, 1'b1);
        do_alloc(3'd3, 32'h20C, 1'b1);
        check_eq("mp_pre_ghr", 32'(spec_ghr_o), 32'h0F);
        alloc_valid_i = 1'b1; alloc_pc_i = 32'h210; alloc_pred_taken_i = 1'b1;
        do_resolve(3'd1, 1'b0);
        alloc_valid_i = 1'b0;
        check_eq("mp_ghr", 32'(spec_ghr_o), 32'h02);
        check_eq("mp_tail", 32'(alloc_tag_o), 32'd2);
        do_resolve(3'd3, 1'b0);
        check_eq("inval_res_ghr", 32'(spec_ghr_o), 32'h02);
        check_eq("inval_res_tail", 32'(alloc_tag_o), 32'd2);
        do_resolve(3'd0, 1'b1);
        check_eq("c_r0_valid", 32'(update_valid_o), 32'd0);
        step();
        check_eq("c_r1_valid", 32'(update_valid_o), 32'd1);
        check_eq("c_r1_pc", update_pc_o, 32'h200);
        check_eq("c_r1_ghr", 32'(update_ghr_o), 32'h00);
        check_eq("c_r1_taken", 32'(update_taken_o), 32'd1);
        step();
        check_eq("c_r2_valid", 32'(update_valid_o), 32'd1);
        check_eq("c_r2_pc", update_pc_o, 32'h204);
        check_eq("c_r2_ghr", 32'(update_ghr_o), 32'h01);
        check_eq("c_r2_taken", 32'(update_taken_o), 32'd0);
        step();
        check_eq("c_r3_valid", 32'(update_valid_o), 32'd0);
        check_eq("c_r3_pc_hold", update_pc_o, 32'h204);
        check_eq("c_upd_count", 32'(pc_log.size()), 32'd2);

        // Fill to capacity; a same-cycle commit must not admit an alloc.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            do_alloc(3'(i), 32'h400 + 32'(i * 4), (i % 2) == 0);
        end
        check_eq("full_ready", 32'(alloc_ready_o), 32'd0);
        check_eq("full_ghr", 32'(spec_ghr_o), 32'hAA);
        alloc_valid_i = 1'b1; alloc_pc_i = 32'h4FF; alloc_pred_taken_i = 1'b1;
        step();
        check_eq("ninth_tag", 32'(alloc_tag_o), 32'd0);
        check_eq("ninth_ghr", 32'(spec_ghr_o), 32'hAA);
        check_eq("ninth_ready", 32'(alloc_ready_o), 32'd0);
        do_resolve(3'd0, 1'b1);
        alloc_valid_i = 1'b1;
        check_eq("full_res_ready", 32'(alloc_ready_o), 32'd0);
        step();
        alloc_valid_i = 1'b0;
        check_eq("full_cmt_ready", 32'(alloc_ready_o), 32'd1);
        check_eq("full_cmt_tag", 32'(alloc_tag_o), 32'd0);
        check_eq("full_cmt_ghr", 32'(spec_ghr_o), 32'hAA);
        check_eq("full_cmt_upd", 32'(update_valid_o), 32'd1);
        check_eq("full_cmt_pc", update_pc_o, 32'h400);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
